// File: rtl/display_pkg.sv
// Shared constants for the display share arbiter: FSM encodings, display geometry and
// the pattern shown when nobody owns the display.
package display_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DISP_W  = DIGITS * DIGIT_W;

  localparam logic [DISP_W-1:0] IDLE_VALUE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first asserted req after index `last`,
// wrapping around, so `last` itself is considered only after every other client.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic            found,
  output logic [2:0]      idx
);

  logic [7:0] req_pad;
  logic [3:0] cand;

  always_comb begin
    req_pad = 8'(req);
    found   = 1'b0;
    idx     = '0;
    cand    = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      // last < NREQ, so a single subtraction is enough to wrap
      cand = {1'b0, last} + 4'(off);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!found && req_pad[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Grants the shared 8-digit display to one of NREQ clients round-robin, with a minimum
// hold time per owner, and registers the owner's digits toward the display multiplexer.
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int unsigned       NREQ        = 4,
  parameter int unsigned       HOLD_CYCLES = 8,
  parameter int unsigned       CNT_W       = 27,
  parameter logic [DISP_W-1:0] IDLE_VALUE  = IDLE_VALUE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [DISP_W-1:0]      digits,
  output logic                   hold_done
);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        last_q, last_d;
  logic [DISP_W-1:0] digits_q, digits_d;

  logic       hold_done_w;
  logic       owner_req;
  logic [7:0] req_pad;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic       take;

  assign req_pad     = 8'(req);
  assign owner_req   = req_pad[owner_q];
  assign hold_done_w = (state_q == StOwn) && (cnt_q == CNT_W'(HOLD_CYCLES));

  // The current owner is masked out so it only ever competes as "someone else" would.
  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req & ~grant_q),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    take    = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_found) take = 1'b1;
      end
      StOwn: begin
        if (!owner_req) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            owner_d = '0;
            cnt_d   = '0;
          end
        end else if (hold_done_w && pick_found) begin
          take = 1'b1;
        end else if (!hold_done_w) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      state_d = StOwn;
      owner_d = pick_idx;
      last_d  = pick_idx;
      cnt_d   = '0;
      for (int i = 0; i < NREQ; i++) grant_d[i] = (pick_idx == 3'(i));
    end

    digits_d = IDLE_VALUE;
    if (state_d == StOwn) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_d == 3'(i)) digits_d = data[i*DISP_W +: DISP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= 3'(NREQ - 1);
      digits_q <= IDLE_VALUE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      digits_q <= digits_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = (state_q == StOwn);
  assign digits    = digits_q;
  assign hold_done = hold_done_w;

endmodule
